// File: rtl/dpi_bus_pkg.sv
// Shared types and the slave-model call hook for the bus write drain path.
// slave_write keeps the C model's (address, data) signature and also records each call.
package dpi_bus_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } bus_wr_t;

  typedef enum logic {IDLE, GAP} drain_state_e;

  // Call record: running call count and the arguments of the most recent call.
  int unsigned call_count;
  logic [31:0] last_addr;
  logic [31:0] last_data;

  function automatic void slave_write(input int address, input int data);
    call_count = call_count + 1;
    last_addr  = address;
    last_data  = data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers wrap modulo DEPTH (power of 2).
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is not reset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_write_dpi_bridge.sv
// Buffers bus write requests and drains them one per call into the slave model,
// with GAP_CYCLES idle cycles enforced after every call.
module bus_write_dpi_bridge
  import dpi_bus_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [31:0]            wr_addr,
  input  logic [31:0]            wr_data,
  input  logic                   drain_en,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [CNT_W-1:0]       issued_cnt
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  bus_wr_t      head;
  bus_wr_t      req;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  drain_state_e state;
  logic [GW-1:0] gap_cnt;

  // Acceptance looks only at the registered occupancy, so a pop never frees a slot early.
  assign wr_ready = !full && !flush && !rst;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state == IDLE) && drain_en && !empty && !flush;
  assign busy     = !empty || (state == GAP);
  assign req      = '{addr: wr_addr, data: wr_data};

  sync_fifo #(
    .WIDTH ($bits(bus_wr_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (req),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      issued_cnt <= '0;
    end else if (flush) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            slave_write(int'(head.addr), int'(head.data));
            issued_cnt <= issued_cnt + CNT_W'(1);
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GW'(GAP_CYCLES - 1);
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_write_dpi_bridge.sv
// Self-checking bench: two bridges (GAP=0 / GAP=2 with a 4-bit call counter) compared
// every edge against a queue-based model that tracks the earliest cycle a call may occur.
module tb_bus_write_dpi_bridge;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        v    [2];
  logic        dr   [2];
  logic        fl   [2];
  logic [31:0] ad   [2];
  logic [31:0] da   [2];
  logic        rdy0, rdy1, busy0, busy1;
  logic [3:0]  fc0, fc1;
  logic [15:0] ic0;
  logic [3:0]  ic1;

  bus_write_dpi_bridge #(.DEPTH(DEPTH), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .wr_valid(v[0]), .wr_ready(rdy0), .wr_addr(ad[0]),
    .wr_data(da[0]), .drain_en(dr[0]), .flush(fl[0]), .fifo_count(fc0),
    .busy(busy0), .issued_cnt(ic0));

  bus_write_dpi_bridge #(.DEPTH(DEPTH), .GAP_CYCLES(2), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .wr_valid(v[1]), .wr_ready(rdy1), .wr_addr(ad[1]),
    .wr_data(da[1]), .drain_en(dr[1]), .flush(fl[1]), .fifo_count(fc1),
    .busy(busy1), .issued_cnt(ic1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pending entries, earliest edge allowed to call, calls made.
  logic [63:0] mq [2][$];
  int          next_ok [2];
  int unsigned mcnt    [2];
  bit          acc     [2];
  int          cyc;
  int unsigned prev_calls;
  int          last_tick_calls;
  int          total;
  int          bad;

  function automatic int gapof(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      next_ok[d] = 0;
      mcnt[d]    = 0;
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      v[d] = 0; dr[d] = 0; fl[d] = 0; ad[d] = '0; da[d] = '0;
    end
  endtask

  // Advance one edge: update the model from the current inputs, then compare after the edge.
  task automatic tick();
    int          ecalls;
    logic [63:0] ecall;
    bit          do_push, do_pop;
    int          delta;
    int          obs_fc, obs_ic, exp_ic;
    bit          obs_busy, obs_rdy, exp_busy, exp_rdy;
    ecalls = 0;
    ecall  = '0;
    for (int d = 0; d < 2; d++) begin
      acc[d] = 0;
      if (rst) begin
        mq[d].delete(); next_ok[d] = 0; mcnt[d] = 0;
      end else if (fl[d]) begin
        mq[d].delete(); next_ok[d] = 0;
      end else begin
        do_push = v[d] && (mq[d].size() < DEPTH);
        do_pop  = dr[d] && (mq[d].size() > 0) && (cyc >= next_ok[d]);
        if (do_pop) begin
          ecall = mq[d].pop_front();
          mcnt[d]++;
          next_ok[d] = cyc + gapof(d) + 1;
          ecalls++;
        end
        if (do_push) begin
          mq[d].push_back({ad[d], da[d]});
          acc[d] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    delta = int'(dpi_bus_pkg::call_count - prev_calls);
    prev_calls = dpi_bus_pkg::call_count;
    last_tick_calls = delta;
    total++;
    if (delta !== ecalls) begin
      bad++;
      $display("FAIL call_count cyc=%0d got=%0d want=%0d", cyc, delta, ecalls);
    end
    if (ecalls == 1) begin
      total++;
      if ({dpi_bus_pkg::last_addr, dpi_bus_pkg::last_data} !== ecall) begin
        bad++;
        $display("FAIL call_args cyc=%0d got=%h_%h want=%h", cyc,
                 dpi_bus_pkg::last_addr, dpi_bus_pkg::last_data, ecall);
      end
    end
    for (int d = 0; d < 2; d++) begin
      obs_fc   = (d == 0) ? int'(fc0) : int'(fc1);
      obs_ic   = (d == 0) ? int'(ic0) : int'(ic1);
      obs_busy = (d == 0) ? busy0 : busy1;
      obs_rdy  = (d == 0) ? rdy0 : rdy1;
      exp_ic   = (d == 0) ? int'(mcnt[d] % 65536) : int'(mcnt[d] % 16);
      exp_busy = (mq[d].size() > 0) || (cyc < next_ok[d]);
      exp_rdy  = !rst && !fl[d] && (mq[d].size() < DEPTH);
      total += 4;
      if (obs_fc !== mq[d].size()) begin
        bad++;
        $display("FAIL fifo_count dut%0d cyc=%0d got=%0d want=%0d", d, cyc, obs_fc, mq[d].size());
      end
      if (obs_ic !== exp_ic) begin
        bad++;
        $display("FAIL issued_cnt dut%0d cyc=%0d got=%0d want=%0d", d, cyc, obs_ic, exp_ic);
      end
      if (obs_busy !== exp_busy) begin
        bad++;
        $display("FAIL busy dut%0d cyc=%0d got=%0b want=%0b", d, cyc, obs_busy, exp_busy);
      end
      if (obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL wr_ready dut%0d cyc=%0d got=%0b want=%0b", d, cyc, obs_rdy, exp_rdy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    #1;
    total++;
    if ({fc0, fc1, ic0, ic1, busy0, busy1, rdy0, rdy1} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {fc0, fc1, ic0, ic1, busy0, busy1, rdy0, rdy1});
    end
    tick();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_single();
    idle_inputs();
    v[0] = 1; dr[0] = 1; ad[0] = 32'h10; da[0] = 32'hA5;
    tick();
    v[0] = 0;
    tick();
    total++;
    if (last_tick_calls !== 1 || ic0 !== 16'd1 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL single_write got calls=%0d ic=%0d busy=%0b want 1/1/0",
               last_tick_calls, ic0, busy0);
    end
    tick();
  endtask

  task automatic test_burst();
    int idx;
    idle_inputs();
    idx = 0;
    v[0] = 1;
    for (int i = 0; i < 11; i++) begin
      ad[0] = idx; da[0] = 32'hB000 + idx;
      tick();
      if (acc[0]) idx++;
    end
    total++;
    if (idx !== 8 || fc0 !== 4'd8 || rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL burst_full got accepts=%0d count=%0d ready=%0b want 8/8/0", idx, fc0, rdy0);
    end
    dr[0] = 1;
    for (int i = 0; i < 14; i++) begin
      ad[0] = idx; da[0] = 32'hB000 + idx;
      tick();
      if (acc[0]) idx++;
      if (idx == 9) v[0] = 0;
    end
  endtask

  task automatic test_gap();
    int t[$];
    idle_inputs();
    v[1] = 1;
    for (int i = 0; i < 3; i++) begin
      ad[1] = 32'h200 + i; da[1] = $urandom;
      tick();
    end
    v[1] = 0; dr[1] = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_tick_calls == 1) t.push_back(cyc);
      if (t.size() == 3 && cyc == t[0] + 7) begin
        total++;
        if (busy1 !== 1'b1) begin
          bad++;
          $display("FAIL gap_busy_e7 got=%0b want=1", busy1);
        end
      end
      if (t.size() == 3 && cyc == t[0] + 8) begin
        total++;
        if (busy1 !== 1'b0) begin
          bad++;
          $display("FAIL gap_busy_e8 got=%0b want=0", busy1);
        end
      end
    end
    total++;
    if (t.size() != 3 || t[1] - t[0] != 3 || t[2] - t[1] != 3) begin
      bad++;
      $display("FAIL gap_spacing got calls=%0d want 3 spaced by 3", t.size());
    end
  endtask

  task automatic test_flush();
    int base;
    idle_inputs();
    base = int'(ic0);
    v[0] = 1;
    for (int i = 0; i < 5; i++) begin
      ad[0] = 32'h300 + i; da[0] = $urandom;
      tick();
    end
    v[0] = 0; dr[0] = 1;
    tick();
    tick();
    fl[0] = 1;
    tick();
    fl[0] = 0;
    total++;
    if (fc0 !== 4'd0 || int'(ic0) - base !== 2) begin
      bad++;
      $display("FAIL flush got count=%0d issued=%0d want 0/2", fc0, int'(ic0) - base);
    end
    tick();
    tick();
    v[0] = 1; ad[0] = 32'h3FF; da[0] = 32'h1234;
    tick();
    v[0] = 0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    v[1] = 1;
    for (int i = 0; i < 4; i++) begin
      ad[1] = 32'h400 + i; da[1] = $urandom;
      tick();
    end
    v[1] = 0; dr[1] = 1;
    tick();
    #2;
    rst = 1;
    model_reset();
    #1;
    total++;
    if ({fc1, ic1, busy1, rdy1, fc0, ic0, busy0, rdy0} !== '0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {fc1, ic1, busy1, rdy1, fc0, ic0, busy0, rdy0});
    end
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    v[0] = 1;
    for (int i = 0; i < 4; i++) begin
      ad[0] = 32'h500 + i; da[0] = $urandom;
      tick();
    end
    dr[0] = 1;
    for (int i = 0; i < 20; i++) begin
      ad[0] = 32'h600 + i; da[0] = $urandom;
      tick();
      total++;
      if (fc0 !== 4'd4) begin
        bad++;
        $display("FAIL b2b_count cyc=%0d got=%0d want=4", cyc, fc0);
      end
    end
    v[0] = 0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
        v[d]  = ($urandom_range(99, 0) < 70);
        dr[d] = ($urandom_range(99, 0) < 60);
        fl[d] = ($urandom_range(99, 0) < 3);
        ad[d] = $urandom;
        da[d] = $urandom;
        tick();
      end
      v[d] = 0; fl[d] = 0; dr[d] = 1;
      for (int i = 0; i < 30; i++) tick();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    last_tick_calls = 0;
    prev_calls = dpi_bus_pkg::call_count;
    model_reset();
    test_reset();
    test_single();
    test_burst();
    test_gap();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
